pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Two-entry skid-buffer pipeline register for an instruction/operand stream.
// The main register drives the outputs; the skid register catches one extra
// entry so that in_ready can be a plain register with no combinational path
// from out_ready.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready registered, = !skid valid)
//   in_addr, in_data     incoming instruction-memory address and payload
//   out_valid/out_ready  downstream handshake
//   out_addr, out_data   address and payload of the head (main) entry
//   flush                drop every held entry (taken branch)
//   occupancy            registered count of held entries, 0..2
//   bubble_cnt           saturating count of cycles with out_ready && !out_valid
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid_r;
  logic              skid_valid_r;
  logic              in_ready_r;
  logic [1:0]        occupancy_r;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic [ADDR_W-1:0] main_addr_r;
  logic [DATA_W-1:0] main_data_r;
  logic [ADDR_W-1:0] skid_addr_r;
  logic [DATA_W-1:0] skid_data_r;

  logic              xfer_in_s;
  logic              xfer_out_s;
  logic              main_valid_s;
  logic              skid_valid_s;
  logic              main_load_in_s;
  logic              main_load_skid_s;
  logic              skid_load_s;
  logic              bubble_inc_s;

  assign xfer_in_s  = in_valid && in_ready_r;
  assign xfer_out_s = main_valid_r && out_ready;

  // Next-state of the valid bits and the data-register load selects.
  always_comb begin
    main_valid_s     = main_valid_r;
    skid_valid_s     = skid_valid_r;
    main_load_in_s   = 1'b0;
    main_load_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      // Flush wins over any handshake in the same cycle.
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (!main_valid_r) begin
      // Empty: skid is necessarily empty too.
      if (xfer_in_s) begin
        main_valid_s   = 1'b1;
        main_load_in_s = 1'b1;
      end else begin
        main_valid_s = 1'b0;
      end
    end else if (!skid_valid_r) begin
      // One entry held.
      if (xfer_in_s && xfer_out_s) begin
        main_load_in_s = 1'b1;
      end else if (xfer_in_s) begin
        skid_valid_s = 1'b1;
        skid_load_s  = 1'b1;
      end else if (xfer_out_s) begin
        main_valid_s = 1'b0;
      end else begin
        main_valid_s = 1'b1;
      end
    end else begin
      // Full: in_ready is low, so only a drain can happen.
      if (xfer_out_s) begin
        main_load_skid_s = 1'b1;
        skid_valid_s     = 1'b0;
      end else begin
        skid_valid_s = 1'b1;
      end
    end
  end

  // A bubble is a cycle where downstream could take data but none is offered.
  assign bubble_inc_s = out_ready && !main_valid_r && (bubble_cnt_r != CNT_MAX);

  // Control state: valid bits, registered in_ready/occupancy, bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
      occupancy_r  <= 2'd0;
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      skid_valid_r <= skid_valid_s;
      in_ready_r   <= !skid_valid_s;
      occupancy_r  <= {1'b0, main_valid_s} + {1'b0, skid_valid_s};
      if (bubble_inc_s) begin
        bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Payload registers: no reset, their contents only matter when valid.
  always_ff @(posedge clk) begin
    if (main_load_in_s) begin
      main_addr_r <= in_addr;
      main_data_r <= in_data;
    end else if (main_load_skid_s) begin
      main_addr_r <= skid_addr_r;
      main_data_r <= skid_data_r;
    end
    if (skid_load_s) begin
      skid_addr_r <= in_addr;
      skid_data_r <= in_data;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = main_valid_r;
  assign out_addr   = main_addr_r;
  assign out_data   = main_data_r;
  assign occupancy  = occupancy_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, in_valid, out_ready, flush;
  logic              in_ready, out_valid;
  logic [ADDR_W-1:0] in_addr, out_addr;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: an ordered list of held entries plus scalar state.
  logic [ADDR_W+DATA_W-1:0] q[$];
  bit m_rdy = 1'b1;
  int m_cnt = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .flush(flush), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at the edge,
  // then compare every output against the model.
  task automatic step();
    int  sz;
    bit  acc, pop;
    logic [ADDR_W+DATA_W-1:0] head;
    @(posedge clk);
    sz  = q.size();
    acc = in_valid && m_rdy;
    pop = (sz > 0) && out_ready;
    if (rst) begin
      q.delete();
      m_rdy = 1'b1;
      m_cnt = 0;
    end else begin
      if (out_ready && sz == 0 && m_cnt < CNT_MAX) m_cnt++;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back({in_addr, in_data});
      end
      m_rdy = (q.size() < 2);
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(m_rdy));
    check("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
    if (q.size() > 0) begin
      head = q[0];
      check("out_addr", 64'(out_addr), 64'(head[ADDR_W+DATA_W-1:DATA_W]));
      check("out_data", 64'(out_data), 64'(head[DATA_W-1:0]));
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_addr = '0; in_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int nxt;
    idle_inputs();
    #2;
    do_reset();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_bubble", 64'(bubble_cnt), 64'd0);

    // First entry, latency 1.
    out_ready = 1'b1;
    push(11'h004, 32'h00500093);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_addr", 64'(out_addr), 64'h004);
    check("first_data", 64'(out_data), 64'h00500093);
    check("first_occ", 64'(occupancy), 64'd1);
    step();

    // Backpressure fills skid, then ordered drain.
    out_ready = 1'b0;
    push(11'h010, 32'hA);
    push(11'h014, 32'hB);
    step();
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_hold_data", 64'(out_data), 64'hA);
    out_ready = 1'b1;
    step();
    check("drain_second", 64'(out_data), 64'hB);
    check("drain_in_ready", 64'(in_ready), 64'd1);
    step();
    check("drain_empty", 64'(out_valid), 64'd0);

    // Flush at occupancy 2 with a coincident offer and drain.
    out_ready = 1'b0;
    push(11'h020, 32'h11);
    push(11'h024, 32'h22);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h33; in_addr = 11'h028;
    step();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("flush_not_captured", 64'(out_valid), 64'd0);

    // Streaming 100 entries.
    do_reset();
    out_ready = 1'b1;
    nxt = 0;
    for (int k = 0; k <= 100; k++) begin
      if (out_valid && out_ready) begin
        check("stream_order", 64'(out_data), 64'(nxt));
        nxt++;
      end
      in_valid = (k < 100);
      in_addr  = ADDR_W'(k);
      in_data  = DATA_W'(k);
      step();
    end
    if (out_valid && out_ready) nxt++;
    check("stream_count", 64'(nxt), 64'd100);
    check("stream_bubble", 64'(bubble_cnt), 64'd1);

    // Bubble counter saturation.
    do_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) step();
    check("bubble_sat", 64'(bubble_cnt), 64'(CNT_MAX));

    // Reset together with flush at occupancy 2.
    out_ready = 1'b0;
    push(11'h030, 32'h44);
    push(11'h034, 32'h55);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    step();
    check("rst_flush_valid", 64'(out_valid), 64'd0);
    check("rst_flush_occ", 64'(occupancy), 64'd0);
    check("rst_flush_rdy", 64'(in_ready), 64'd1);
    check("rst_flush_bubble", 64'(bubble_cnt), 64'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    check("rst_no_out", 64'(out_valid), 64'd0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 127) == 0);
      in_addr   = ADDR_W'($urandom);
      in_data   = DATA_W'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
